// File: rtl/ecc_ladder_ctrl.sv
// Scalar-multiplication sequencer: MSB-first double/add-always ladder driving
// external point-double and add engines. Timing depends only on the leading one of k.
module ecc_ladder_ctrl #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_px,
  input  logic [WIDTH-1:0] i_py,
  output logic             o_busy,
  output logic             o_finished,
  output logic             o_error,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_dbl_start,
  output logic [WIDTH-1:0] o_dbl_x,
  output logic [WIDTH-1:0] o_dbl_y,
  input  logic             i_dbl_finish,
  input  logic [WIDTH-1:0] i_dbl_x,
  input  logic [WIDTH-1:0] i_dbl_y,
  output logic             o_add_start,
  output logic [WIDTH-1:0] o_add_x1,
  output logic [WIDTH-1:0] o_add_y1,
  output logic [WIDTH-1:0] o_add_x2,
  output logic [WIDTH-1:0] o_add_y2,
  output logic             o_add_sel,
  input  logic             i_add_finish,
  input  logic [WIDTH-1:0] i_add_x,
  input  logic [WIDTH-1:0] i_add_y
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] PT_INF   = '1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] px_q;
  logic [WIDTH-1:0] py_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] ry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             busy_q;
  logic             fin_q;
  logic             err_q;
  logic             dbl_start_q;
  logic             add_start_q;
  logic             add_sel_q;
  logic [WIDTH-1:0] res_x_q;
  logic [WIDTH-1:0] res_y_q;

  logic bit_now;
  logic idx_last;
  logic wait_expired;

  assign bit_now      = k_q[idx_q];
  assign idx_last     = (idx_q == '0);
  assign wait_expired = (wait_cnt == CNT_LAST);

  // R is the only operand that moves; engines read it straight from the register,
  // so it is frozen from each start pulse through the matching finish cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      k_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      idx_q       <= '0;
      wait_cnt    <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      dbl_start_q <= 1'b0;
      add_start_q <= 1'b0;
      add_sel_q   <= 1'b0;
      res_x_q     <= PT_INF;
      res_y_q     <= PT_INF;
    end else begin
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      dbl_start_q <= 1'b0;
      add_start_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            k_q    <= i_k;
            px_q   <= i_px;
            py_q   <= i_py;
            idx_q  <= IDX_TOP;
            busy_q <= 1'b1;
            state  <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (bit_now) begin
            rx_q <= px_q;
            ry_q <= py_q;
            if (idx_last) begin
              res_x_q <= px_q;
              res_y_q <= py_q;
              fin_q   <= 1'b1;
              state   <= ST_DONE;
            end else begin
              idx_q       <= idx_q - 1'b1;
              dbl_start_q <= 1'b1;
              state       <= ST_DBL_REQ;
            end
          end else if (idx_last) begin
            // k = 0: result is the point at infinity
            rx_q    <= PT_INF;
            ry_q    <= PT_INF;
            res_x_q <= PT_INF;
            res_y_q <= PT_INF;
            fin_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end

        ST_DBL_REQ: begin
          wait_cnt <= '0;
          state    <= ST_DBL_WAIT;
        end

        ST_DBL_WAIT: begin
          if (i_dbl_finish) begin
            rx_q        <= i_dbl_x;
            ry_q        <= i_dbl_y;
            add_sel_q   <= bit_now;
            add_start_q <= 1'b1;
            state       <= ST_ADD_REQ;
          end else if (wait_expired) begin
            rx_q    <= PT_INF;
            ry_q    <= PT_INF;
            res_x_q <= PT_INF;
            res_y_q <= PT_INF;
            fin_q   <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_ADD_REQ: begin
          wait_cnt <= '0;
          state    <= ST_ADD_WAIT;
        end

        ST_ADD_WAIT: begin
          if (i_add_finish) begin
            rx_q <= i_add_x;
            ry_q <= i_add_y;
            if (idx_last) begin
              res_x_q <= i_add_x;
              res_y_q <= i_add_y;
              fin_q   <= 1'b1;
              state   <= ST_DONE;
            end else begin
              idx_q       <= idx_q - 1'b1;
              dbl_start_q <= 1'b1;
              state       <= ST_DBL_REQ;
            end
          end else if (wait_expired) begin
            rx_q    <= PT_INF;
            ry_q    <= PT_INF;
            res_x_q <= PT_INF;
            res_y_q <= PT_INF;
            fin_q   <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_finished  = fin_q;
  assign o_error     = err_q;
  assign o_result_x  = res_x_q;
  assign o_result_y  = res_y_q;
  assign o_dbl_start = dbl_start_q;
  assign o_dbl_x     = rx_q;
  assign o_dbl_y     = ry_q;
  assign o_add_start = add_start_q;
  assign o_add_x1    = rx_q;
  assign o_add_y1    = ry_q;
  assign o_add_x2    = px_q;
  assign o_add_y2    = py_q;
  assign o_add_sel   = add_sel_q;

endmodule

// File: tb/tb_ecc_ladder_ctrl.sv
// Bench for ecc_ladder_ctrl: symbolic stub engines, vector table, corner sequences
// and randomized jobs checked against a plain double-and-add reference.
module tb_ecc_ladder_ctrl;

  localparam int W  = 16;
  localparam int TO = 16;
  localparam logic [W-1:0] INF = '1;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_k = '0, i_px = '0, i_py = '0;
  logic         o_busy, o_finished, o_error;
  logic [W-1:0] o_result_x, o_result_y;
  logic         o_dbl_start, i_dbl_finish;
  logic [W-1:0] o_dbl_x, o_dbl_y, i_dbl_x, i_dbl_y;
  logic         o_add_start, o_add_sel, i_add_finish;
  logic [W-1:0] o_add_x1, o_add_y1, o_add_x2, o_add_y2, i_add_x, i_add_y;

  ecc_ladder_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_k(i_k), .i_px(i_px), .i_py(i_py),
    .o_busy(o_busy), .o_finished(o_finished), .o_error(o_error),
    .o_result_x(o_result_x), .o_result_y(o_result_y),
    .o_dbl_start(o_dbl_start), .o_dbl_x(o_dbl_x), .o_dbl_y(o_dbl_y),
    .i_dbl_finish(i_dbl_finish), .i_dbl_x(i_dbl_x), .i_dbl_y(i_dbl_y),
    .o_add_start(o_add_start), .o_add_x1(o_add_x1), .o_add_y1(o_add_y1),
    .o_add_x2(o_add_x2), .o_add_y2(o_add_y2), .o_add_sel(o_add_sel),
    .i_add_finish(i_add_finish), .i_add_x(i_add_x), .i_add_y(i_add_y)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Symbolic engine arithmetic shared by the stubs and the reference ladder
  function automatic logic [W-1:0] f_dbl_x(input logic [W-1:0] x);
    return W'(x * 3 + 1);
  endfunction
  function automatic logic [W-1:0] f_dbl_y(input logic [W-1:0] y);
    return W'(y * 5 + 2);
  endfunction

  function automatic int lead_one(input logic [W-1:0] k);
    int m = 0;
    for (int i = 0; i < W; i++) if (k[i]) m = i;
    return m;
  endfunction

  function automatic logic [2*W-1:0] ladder_ref(input logic [W-1:0] k, px, py);
    logic [W-1:0] rx, ry;
    if (k == '0) return {INF, INF};
    rx = px;
    ry = py;
    for (int i = lead_one(k) - 1; i >= 0; i--) begin
      rx = f_dbl_x(rx);
      ry = f_dbl_y(ry);
      if (k[i]) begin
        rx = rx + px;
        ry = ry ^ py;
      end
    end
    return {rx, ry};
  endfunction

  // Stub engines: fixed-latency countdown, result computed from live operands
  int   dbl_lat = 10, add_lat = 10;
  bit   add_hang = 1'b0;
  int   dbl_cnt = 0, add_cnt = 0;
  int   n_dbl = 0, n_add = 0, stab_err = 0;
  logic [31:0] sel_log = '0;
  logic [W-1:0] cap_dx, cap_dy, cap_ax1, cap_ay1, cap_ax2, cap_ay2;
  logic cap_sel;

  always @(posedge i_clk) begin
    if (o_dbl_start) begin
      dbl_cnt <= dbl_lat;
      n_dbl   <= n_dbl + 1;
      cap_dx  <= o_dbl_x;
      cap_dy  <= o_dbl_y;
    end else if (dbl_cnt > 0) begin
      dbl_cnt <= dbl_cnt - 1;
      if (o_busy && (o_dbl_x !== cap_dx || o_dbl_y !== cap_dy)) stab_err <= stab_err + 1;
    end
    if (o_add_start) begin
      add_cnt <= add_lat;
      n_add   <= n_add + 1;
      sel_log <= {sel_log[30:0], o_add_sel};
      cap_ax1 <= o_add_x1;
      cap_ay1 <= o_add_y1;
      cap_ax2 <= o_add_x2;
      cap_ay2 <= o_add_y2;
      cap_sel <= o_add_sel;
    end else if (add_cnt > 0) begin
      add_cnt <= add_cnt - 1;
      if (o_busy && (o_add_x1 !== cap_ax1 || o_add_y1 !== cap_ay1 || o_add_x2 !== cap_ax2 ||
                     o_add_y2 !== cap_ay2 || o_add_sel !== cap_sel))
        stab_err <= stab_err + 1;
    end
  end

  assign i_dbl_finish = (dbl_cnt == 1);
  assign i_dbl_x      = f_dbl_x(o_dbl_x);
  assign i_dbl_y      = f_dbl_y(o_dbl_y);
  assign i_add_finish = (add_cnt == 1) && !add_hang;
  assign i_add_x      = o_add_sel ? o_add_x1 + o_add_x2 : o_add_x1;
  assign i_add_y      = o_add_sel ? o_add_y1 ^ o_add_y2 : o_add_y1;

  // Runs one job from an idle controller and checks everything observable about it.
  task automatic do_job(input string nm, input logic [W-1:0] k, px, py, input int inject,
                        input logic [W-1:0] ex, ey, input int ecyc, input int eeng,
                        input logic [31:0] esel, input logic eerr);
    int cyc, busy_bad, d0, a0, s0;
    logic [31:0] mask;
    d0 = n_dbl;
    a0 = n_add;
    s0 = stab_err;
    @(negedge i_clk);
    i_start = 1'b1;
    i_k = k;
    i_px = px;
    i_py = py;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_k  = W'($urandom);
    i_px = W'($urandom);
    i_py = W'($urandom);
    cyc = 1;
    busy_bad = 0;
    while (!o_finished && cyc < 5000) begin
      if (!o_busy) busy_bad++;
      i_start = (inject != 0 && cyc == inject);
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_start = 1'b0;
    mask = (32'd1 << eeng) - 32'd1;
    check({nm, "_finish_seen"}, 64'(o_finished), 64'd1);
    check({nm, "_cycles"}, 64'(cyc), 64'(ecyc));
    check({nm, "_res_x"}, 64'(o_result_x), 64'(ex));
    check({nm, "_res_y"}, 64'(o_result_y), 64'(ey));
    check({nm, "_error"}, 64'(o_error), 64'(eerr));
    check({nm, "_dbl_starts"}, 64'(n_dbl - d0), 64'(eeng));
    check({nm, "_add_starts"}, 64'(n_add - a0), 64'(eeng));
    check({nm, "_add_sel_seq"}, 64'(sel_log & mask), 64'(esel & mask));
    check({nm, "_busy_gaps"}, 64'(busy_bad), 64'd0);
    check({nm, "_operand_moves"}, 64'(stab_err - s0), 64'd0);
    @(posedge i_clk);
    #1;
    check({nm, "_finish_pulse_len"}, 64'(o_finished), 64'd0);
    check({nm, "_busy_after"}, 64'(o_busy), 64'd0);
  endtask

  typedef struct {
    string        nm;
    logic [W-1:0] k, px, py, ex, ey;
    int           cyc, eng;
    logic [31:0]  sel;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"k0", 16'd0, 16'd5, 16'd7, INF,     INF,      17, 0, 32'd0};
    tbl[1] = '{"k1", 16'd1, 16'd5, 16'd7, 16'd5,   16'd7,    17, 0, 32'd0};
    tbl[2] = '{"k5", 16'd5, 16'd5, 16'd7, 16'd54,  16'd188,  59, 2, 32'b01};
    tbl[3] = '{"k4", 16'd4, 16'd5, 16'd7, 16'd49,  16'd187,  59, 2, 32'b00};
    tbl[4] = '{"k7", 16'd7, 16'd5, 16'd7, 16'd69,  16'd171,  59, 2, 32'b11};

    // Reset values
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_finished", 64'(o_finished), 64'd0);
    check("rst_error", 64'(o_error), 64'd0);
    check("rst_result", 64'({o_result_x, o_result_y}), 64'({INF, INF}));
    check("rst_starts", 64'({o_dbl_start, o_add_start, o_add_sel}), 64'd0);
    check("rst_operands", 64'({o_dbl_x, o_dbl_y, o_add_x2, o_add_y2}), 64'd0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    for (int i = 0; i < 5; i++)
      do_job(tbl[i].nm, tbl[i].k, tbl[i].px, tbl[i].py, 0, tbl[i].ex, tbl[i].ey,
             tbl[i].cyc, tbl[i].eng, tbl[i].sel, 1'b0);

    // i_start during the first ADD_WAIT (cycle 30 of a k=5 job) must be ignored
    do_job("start_in_wait", 16'd5, 16'd5, 16'd7, 30, 16'd54, 16'd188, 59, 2, 32'b01, 1'b0);

    // Reset in the middle of DBL_WAIT; the stub's late finish must be ignored
    @(negedge i_clk);
    i_start = 1'b1;
    i_k = 16'd5;
    i_px = 16'd5;
    i_py = 16'd7;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (19) @(posedge i_clk);
    #1;
    check("midrst_pre_busy", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_finished", 64'(o_finished), 64'd0);
    check("midrst_result", 64'({o_result_x, o_result_y}), 64'({INF, INF}));
    check("midrst_operands", 64'({o_dbl_x, o_dbl_y, o_add_x2, o_add_y2}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    begin
      int fins, busys, d0;
      fins = 0;
      busys = 0;
      d0 = n_dbl;
      for (int c = 0; c < 20; c++) begin
        @(posedge i_clk);
        #1;
        if (o_finished) fins++;
        if (o_busy) busys++;
      end
      check("midrst_stray_finish", 64'(fins), 64'd0);
      check("midrst_stray_busy", 64'(busys), 64'd0);
      check("midrst_stray_dbl", 64'(n_dbl - d0), 64'd0);
    end
    do_job("after_rst", 16'd7, 16'd5, 16'd7, 0, 16'd69, 16'd171, 59, 2, 32'b11, 1'b0);

    // Add engine never answers: abort 16 cycles into ADD_WAIT (14+1+10+1+16+1)
    add_hang = 1'b1;
    do_job("timeout", 16'd5, 16'd5, 16'd7, 0, INF, INF, 43, 1, 32'b0, 1'b1);
    add_hang = 1'b0;
    do_job("after_timeout", 16'd5, 16'd5, 16'd7, 0, 16'd54, 16'd188, 59, 2, 32'b01, 1'b0);

    // Randomized jobs against the reference ladder and latency formula
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] k, px, py;
      logic [2*W-1:0] r;
      int m;
      k  = W'($urandom) >> $urandom_range(0, W - 1);
      px = W'($urandom);
      py = W'($urandom);
      dbl_lat = $urandom_range(1, 12);
      add_lat = $urandom_range(1, 12);
      m = (k == '0) ? 0 : lead_one(k);
      r = ladder_ref(k, px, py);
      do_job($sformatf("rand%0d", n), k, px, py, 0, r[2*W-1:W], r[W-1:0],
             (W - m) + m * (dbl_lat + add_lat + 2) + 1, m, 32'(k), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ecc_ladder_ctrl.md
Name: ecc_ladder_ctrl

Overview:
- Scalar-multiplication sequencer: computes Q = k*P by running a point-double engine and a constant-time add-always engine bit by bit, MSB first.
- Every non-leading scalar bit costs exactly one double plus one add-always, whatever the bit value. Timing therefore depends only on the position of the leading one of k.
- The block owns the operand registers for both engines and drives their start pulses. It adds no arithmetic of its own.

Parameters:
- WIDTH, 256, bit width of scalar, coordinates and modulus.
- TIMEOUT, 4096, maximum cycles allowed in one engine wait state before an error abort.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request pulse; accepted only in IDLE.
- i_k  in  WIDTH  scalar.
- i_px  in  WIDTH  base point x.
- i_py  in  WIDTH  base point y.
- o_busy  out  1  high from the cycle after acceptance until DONE completes.
- o_finished  out  1  one-cycle pulse when the result is valid.
- o_error  out  1  one-cycle pulse, coincident with o_finished, on timeout.
- o_result_x  out  WIDTH  Q.x.
- o_result_y  out  WIDTH  Q.y.
- o_dbl_start  out  1  one-cycle start pulse to the double engine.
- o_dbl_x  out  WIDTH  double engine operand x (R.x).
- o_dbl_y  out  WIDTH  double engine operand y (R.y).
- i_dbl_finish  in  1  double engine done pulse.
- i_dbl_x  in  WIDTH  double engine result x.
- i_dbl_y  in  WIDTH  double engine result y.
- o_add_start  out  1  one-cycle start pulse to the add-always engine.
- o_add_x1  out  WIDTH  add engine x1 (R.x).
- o_add_y1  out  WIDTH  add engine y1 (R.y).
- o_add_x2  out  WIDTH  add engine x2 (P.x).
- o_add_y2  out  WIDTH  add engine y2 (P.y).
- o_add_sel  out  1  add flag: 1 = return R+P, 0 = return R after full compute time.
- i_add_finish  in  1  add engine done pulse.
- i_add_x  in  WIDTH  add engine result x.
- i_add_y  in  WIDTH  add engine result y.

Behaviour:
- Point at infinity is encoded as x = y = all-ones. The block passes it through unchanged and never tests for it.
- Reset (async, i_rst_n=0):
  - state goes to IDLE;
  - all outputs are 0, except o_result_x and o_result_y, which are all-ones;
  - internal R, idx and the timeout counter clear.
  - Reset mid-operation abandons the job with no finish pulse. Late engine finish pulses after reset are ignored.
- IDLE: on i_start, latch k, P; set idx = WIDTH-1; go to SCAN. i_start in any other state is ignored.
- SCAN, one bit per cycle:
  - If k[idx]=1: set R = P.
    - If idx = 0, go to DONE.
    - Otherwise decrement idx and go to DBL_REQ.
  - If k[idx]=0 and idx = 0: set R = infinity and go to DONE (k = 0 case).
  - Otherwise decrement idx and stay in SCAN.
- DBL_REQ: o_dbl_start=1 for exactly this cycle, with o_dbl_x/y = R; go to DBL_WAIT.
- DBL_WAIT: on i_dbl_finish, set R = (i_dbl_x, i_dbl_y) and go to ADD_REQ.
- ADD_REQ: o_add_start=1 for exactly this cycle, with o_add_sel = k[idx]; go to ADD_WAIT.
- ADD_WAIT: on i_add_finish, set R = (i_add_x, i_add_y).
  - If idx = 0, go to DONE.
  - Otherwise decrement idx and go to DBL_REQ.
- DONE: o_result = R; o_finished=1 for one cycle; go to IDLE.
  - Results hold until the next DONE or reset.
  - A new i_start is accepted in the cycle after DONE, not in DONE itself.
- Operand stability: engine operand outputs are registered and stay constant from the start pulse through the finish cycle.
  - o_add_x2/y2 stay at P for the whole job.
  - The engines latch nothing themselves; the controller must not change operands while they run.
- Finish pulses arriving in any state other than the matching WAIT state are ignored.
- Timeout:
  - The counter clears on entry to DBL_WAIT or ADD_WAIT and increments each waiting cycle.
  - On reaching TIMEOUT without a finish: result = infinity, o_finished=1 and o_error=1 together, go to IDLE.
- Latency, with leading one at bit m and engine latencies Ld and La:
  - (WIDTH-1-m) + 1 scan cycles;
  - plus m*(Ld + La + 2) engine cycles;
  - plus 1 DONE cycle.
  - Latency is independent of the lower bits of k.

Test Plan:
- Stub engines with fixed 10-cycle latency and deterministic symbolic results.
- k=0 -> o_finished after WIDTH+1 cycles; result all-ones; no engine starts; o_error=0.
- k=1, P=(5,7) -> result (5,7); zero dbl/add starts.
- k=5 (101b) -> 2 dbl starts and 2 add starts; o_add_sel sequence 0,1; total cycle count matches the latency formula; operands held stable during each wait.
- k=4 vs k=7 -> identical total cycles and start counts; o_add_sel sequences 0,0 and 1,1.
- i_start pulsed during ADD_WAIT -> ignored, first job completes unchanged. Reset asserted mid DBL_WAIT -> all outputs at reset values, then a stray i_dbl_finish is ignored and no finish pulse appears.
- Add stub never finishes, TIMEOUT=16 -> o_finished and o_error pulse together exactly 16 cycles after ADD_WAIT entry; result all-ones; next start works normally.
